// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for a multi-cycle RV32I subset datapath (R-type, addi, lw, sw, beq).
// Memory states wait on mem_ready with a bounded count; illegal opcodes and timeouts fault.
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StFault   = 4'd10
    } state_e;

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_e            r_state;
    state_e            w_state_next;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_next;
    logic [1:0]        r_fault_code;
    logic [1:0]        w_fault_code_next;
    logic              w_waiting;
    logic              w_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StFetch;
            r_cnt        <= '0;
            r_fault_code <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_fault_code <= w_fault_code_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_fault_code_next = r_fault_code;
        w_waiting         = 1'b0;
        w_expired         = (TIMEOUT != 0) && (r_cnt == CntLast);
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 1'b0;
        fault      = 1'b0;

        case (r_state)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) w_state_next = StDecode;
                else           w_waiting    = 1'b1;
            end
            StDecode: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OpR:              w_state_next = StExecR;
                    OpI:              w_state_next = StExecI;
                    OpLoad, OpStore:  w_state_next = StMemAddr;
                    OpBranch:         w_state_next = StBranch;
                    default: begin
                        w_state_next      = StFault;
                        w_fault_code_next = 2'b01;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = (opcode == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) w_state_next = StMemWb;
                else           w_waiting    = 1'b1;
            end
            StMemWb: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                w_state_next = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) w_state_next = StFetch;
                else           w_waiting    = 1'b1;
            end
            StExecR: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                w_state_next = StAluWb;
            end
            StExecI: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = StAluWb;
            end
            StAluWb: begin
                reg_write    = 1'b1;
                w_state_next = StFetch;
            end
            StBranch: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b01;
                pc_source    = 1'b1;
                pc_write     = zero;
                w_state_next = StFetch;
            end
            StFault: begin
                fault = 1'b1;
            end
            default: w_state_next = StFetch;
        endcase

        // A wait that hits the limit overrides the stay-in-state decision.
        if (w_waiting && w_expired) begin
            w_state_next      = StFault;
            w_fault_code_next = 2'b10;
        end

        if (w_state_next != r_state) w_cnt_next = '0;
        else if (w_waiting)          w_cnt_next = r_cnt + CntW'(1);
        else                         w_cnt_next = r_cnt;
    end

    assign fault_code = r_fault_code;
    assign state      = r_state;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the RV32I subset datapath (R-type, addi, lw, sw, beq). It replaces single-cycle decode with a Moore state machine that steps one shared ALU and one shared instruction/data memory port through fetch, decode, execute, memory and write-back cycles. It handles a ready-based memory handshake with a bounded wait, and traps illegal opcodes and memory timeouts into a sticky fault state.

## Interface
- TIMEOUT, default 15: maximum cycles a memory state waits with mem_ready low before faulting; 0 disables the timeout.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write  out  1  load the PC.
- ir_write  out  1  load the instruction register.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = memory data register.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct fields.
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- fault  out  1  high while in FAULT.
- fault_code  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout; held until reset.
- state  out  4  current state encoding, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, FAULT=10. Codes 11-15 are unused; if entered, go to FETCH next cycle with all outputs low.
- Output defaults: every output is 0 unless listed for the current state.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready: ir_write=1, pc_write=1 (PC ← PC+4), next state DECODE.
  - Else stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut ← PC+imm (branch target).
  - Next state by opcode: 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 or 0100011 → MEM_ADDR; 1100011 → BRANCH.
  - Any other opcode → FAULT with fault_code=01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=1, pc_write=zero. Next FETCH.
- FAULT: fault=1, all other control outputs 0. The state is absorbing; only rst leaves it.
- Wait counter:
  - Width is clog2(TIMEOUT+1); it clears on every state change.
  - In FETCH, MEM_RD or MEM_WR with mem_ready=0: if TIMEOUT≠0 and the count equals TIMEOUT-1, next state is FAULT with fault_code=10. Otherwise the count increments.
  - mem_ready high on the TIMEOUT-th waiting cycle is still accepted.

## Timing
- Reset: state=FETCH, wait counter=0, fault_code=00. All outputs take their FETCH values immediately, asynchronously (mem_read=1, alu_src_b=01, all others 0).
- Outputs are combinational from the state register only, except pc_write and ir_write (which also depend on mem_ready in FETCH) and pc_write in BRANCH (which depends on zero).
- State and the wait counter update on the rising clock edge.
- Latency with zero-wait memory, in cycles: R-type 4, addi 4, lw 5, sw 4, beq 3. Each extra mem_ready-low cycle in a memory state adds one cycle.
- The opcode input is sampled only in DECODE and MEM_ADDR. The instruction register must hold it stable from the FETCH ir_write edge through MEM_ADDR.
- rst asserted mid-instruction aborts it: no further pc_write, reg_write or mem_write after the reset edge, and fetching restarts at FETCH.

## Test plan
- Reset: hold rst, then release with mem_ready=1 → state=0, mem_read=1, fault=0. In the first cycle pc_write=1 and ir_write=1.
- addi (opcode 0010011) with mem_ready tied to 1 → state sequence 0,1,7,8,0. reg_write=1 only in state 8, with mem_to_reg=0.
- lw with mem_ready low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0. i_or_d=1 and mem_read=1 throughout state 3.
- beq → sequence 0,1,9,0. With zero=1: pc_write=1 and pc_source=1 in state 9. Repeat with zero=0: pc_write=0.
- Opcode 1111111 in DECODE → FAULT next cycle, fault=1, fault_code=01. The block remains in FAULT for 20 cycles with no write enables asserted.
- TIMEOUT=4, sw with mem_ready held low → exactly 4 cycles in MEM_WR, then FAULT with fault_code=10. A repeat with mem_ready high on the 4th MEM_WR cycle returns to FETCH with no fault.
